// File: rtl/fetch_unit.sv
// Instruction fetch stage: RAM read port, DEPTH-entry prefetch FIFO, redirect flush.
// reset_n is an active-high synchronous reset. Optional feature macro: FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        i_req,
  output logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        out_misalign
`endif
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW:0]     DEPTH_L  = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0]   ONE_PTR  = AW'(1);
  localparam logic [CW-1:0]   ONE_CNT  = CW'(1);
  localparam logic [31:0]     NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_r;
  logic [31:0]     fetch_pc_r;
  logic [31:0]     inflight_pc_r;
  logic            inflight_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [31:0]     mem_instr_r [DEPTH];
  logic [31:0]     mem_pc_r    [DEPTH];
`ifdef FETCH_MISALIGN_CHK_EN
  logic            mem_mis_r   [DEPTH];
`endif

  logic [CW:0]     occ_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic            mis_redirect_s;

  // Credit = buffered entries plus the read still in flight; never exceeds DEPTH
  assign occ_s     = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
  assign issue_s   = (state_r == ST_RUN) && (occ_s < DEPTH_L) && !redirect_valid;
  assign push_s    = inflight_r && !redirect_valid;
  assign out_valid = (count_r != {CW{1'b0}});
  assign pop_s     = out_valid && out_ready;

`ifdef FETCH_MISALIGN_CHK_EN
  assign mis_redirect_s = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign out_misalign   = out_valid ? mem_mis_r[rd_ptr_r] : 1'b0;
`else
  assign mis_redirect_s = 1'b0;
`endif

  assign i_req     = issue_s;
  assign i_addr    = fetch_pc_r;
  assign out_instr = out_valid ? mem_instr_r[rd_ptr_r] : 32'h0000_0000;
  assign out_pc    = out_valid ? mem_pc_r[rd_ptr_r]    : 32'h0000_0000;

  // Control state: FSM, fetch PC, in-flight read tracking and FIFO pointers
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_r       <= ST_BOOT;
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else if (redirect_valid) begin
      // Flush everything; the response arriving this cycle is dropped with it
      inflight_r <= 1'b0;
      rd_ptr_r   <= {AW{1'b0}};
      if (mis_redirect_s) begin
        state_r    <= ST_HALT;
        fetch_pc_r <= redirect_pc;
        wr_ptr_r   <= ONE_PTR;
        count_r    <= ONE_CNT;
      end else begin
        state_r    <= ST_RUN;
        fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
        wr_ptr_r   <= {AW{1'b0}};
        count_r    <= {CW{1'b0}};
      end
    end else begin
      case (state_r)
        ST_BOOT: state_r <= ST_RUN;
        ST_RUN:  state_r <= ST_RUN;
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_BOOT;
      endcase
      inflight_r <= issue_s;
      if (issue_s) begin
        fetch_pc_r    <= fetch_pc_r + 32'd4;
        inflight_pc_r <= fetch_pc_r;
      end
      if (push_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + ONE_PTR;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Prefetch storage; a misaligned-target marker always lands in the freshly flushed slot 0
  always_ff @(posedge clk) begin
    if (!reset_n && mis_redirect_s) begin
      mem_pc_r[0]    <= redirect_pc;
      mem_instr_r[0] <= NOP_INSN;
`ifdef FETCH_MISALIGN_CHK_EN
      mem_mis_r[0]   <= 1'b1;
`endif
    end else if (!reset_n && push_s) begin
      mem_pc_r[wr_ptr_r]    <= inflight_pc_r;
      mem_instr_r[wr_ptr_r] <= i_data;
`ifdef FETCH_MISALIGN_CHK_EN
      mem_mis_r[wr_ptr_r]   <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against
// a transaction-level model (queue of issued fetches, flushed on redirect).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        out_misalign;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    , .out_misalign(out_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Instruction RAM: content is a hash of the address, returned one cycle after the request
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic        req_q = 1'b0;
  logic [31:0] addr_q = 32'h0;
  always @(posedge clk) begin
    req_q  <= i_req;
    addr_q <= i_addr;
  end
  assign i_data = req_q ? memf(addr_q) : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
    logic        mis;
  } ent_t;

  ent_t        q[$];
  logic        m_boot, m_run;
  logic [31:0] m_pc;
  int          cyc;
  int          errors = 0;
  int          checks = 0;
  int          n_obs_req;
  logic        obs_req, obs_valid, obs_mis;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    reset_n        = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    q.delete();
    m_boot = 1'b1; m_run = 1'b0; m_pc = RESET_PC; cyc = 0;
    check_eq("rst_i_req",     32'(i_req),     32'd0);
    check_eq("rst_i_addr",    i_addr,         RESET_PC);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_pc",    out_pc,         32'd0);
    check_eq("rst_out_instr", out_instr,      32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    check_eq("rst_out_mis",   32'(out_misalign), 32'd0);
`endif
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic exp_req, exp_valid;
    ent_t e;
    redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(negedge clk);
    obs_req = i_req; obs_addr = i_addr; obs_valid = out_valid;
    obs_pc = out_pc; obs_instr = out_instr;
    n_obs_req += int'(i_req);
`ifdef FETCH_MISALIGN_CHK_EN
    obs_mis = out_misalign;
`else
    obs_mis = 1'b0;
`endif
    exp_req = m_run && !rv && (q.size() < DEPTH);
    check_eq("i_req", 32'(i_req), 32'(exp_req));
    if (exp_req) check_eq("i_addr", i_addr, m_pc);
    exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
    e = '{32'h0, 0, 1'b0};
    if (exp_valid) e = q[0];
    check_eq("out_pc", out_pc, exp_valid ? e.pc : 32'h0);
    check_eq("out_instr", out_instr, !exp_valid ? 32'h0 : (e.mis ? NOP_INSN : memf(e.pc)));
`ifdef FETCH_MISALIGN_CHK_EN
    check_eq("out_misalign", 32'(out_misalign), 32'(exp_valid && e.mis));
`endif
    if (exp_valid && rdy) void'(q.pop_front());
    if (rv) begin
      q.delete();
      m_boot = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (rpc[1:0] != 2'b00) begin
        q.push_back('{rpc, cyc - 1, 1'b1});
        m_run = 1'b0;
      end else begin
        m_run = 1'b1;
        m_pc  = rpc;
      end
`else
      m_run = 1'b1;
      m_pc  = rpc & 32'hFFFF_FFFC;
`endif
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_run  = 1'b1;
    end else if (exp_req) begin
      q.push_back('{m_pc, cyc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found;
    logic        rv, rdy;
    logic [31:0] rpc;
    int          sel;

    // 1: boot latency and steady-state streaming
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (c == 0) check_eq("t1_boot_req", 32'(obs_req), 32'd0);
      if (c == 1) check_eq("t1_first_addr", obs_addr, RESET_PC);
      if (c >= 3) check_eq("t1_pc", obs_pc, RESET_PC + 32'(4 * (c - 3)));
    end

    // 2: backpressure fills exactly DEPTH, then drains in order and resumes
    do_reset();
    n_obs_req = 0;
    for (int c = 0; c < 10; c++) step(1'b0, 32'h0, 1'b0);
    check_eq("t2_req_count", 32'(n_obs_req), 32'd4);
    check_eq("t2_req_held", 32'(obs_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'h0, 1'b1);
      check_eq("t2_pop_pc", obs_pc, RESET_PC + 32'(4 * k));
      if (k == 1) check_eq("t2_resume_addr", obs_addr, 32'h8000_0010);
    end

    // 3: redirect with 3 buffered entries and one read in flight
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h8000_0100, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check_eq("t3_valid_flushed", 32'(obs_valid), 32'd0);
    check_eq("t3_req", 32'(obs_req), 32'd1);
    check_eq("t3_addr", obs_addr, 32'h8000_0100);
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        found = 1'b1;
        check_eq("t3_first_pc", obs_pc, 32'h8000_0100);
      end
    end
    check_eq("t3_valid_seen", 32'(found), 32'd1);

    // 4: full FIFO, pop and redirect in the same cycle
    do_reset();
    for (int c = 0; c < 8; c++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h8000_0200, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check_eq("t4_empty", 32'(obs_valid), 32'd0);
    check_eq("t4_addr", obs_addr, 32'h8000_0200);
    for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 1'b1);

    // 5: reset while a request is in flight
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1);
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check_eq("t5_restart_addr", obs_addr, RESET_PC);

`ifdef FETCH_MISALIGN_CHK_EN
    // 6: misaligned redirect produces one marker entry and halts fetch
    for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h8000_0102, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check_eq("t6_mis", 32'(obs_mis), 32'd1);
    check_eq("t6_pc", obs_pc, 32'h8000_0102);
    check_eq("t6_instr", obs_instr, NOP_INSN);
    for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1);
    check_eq("t6_halted", 32'(obs_req), 32'd0);
    step(1'b1, 32'h8000_0200, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check_eq("t6_resume_addr", obs_addr, 32'h8000_0200);
`endif

    // Random traffic: backpressure, redirects (incl. wrap region, odd low bits), resets
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      sel = int'($urandom_range(0, 3));
      if (sel == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else rpc = RESET_PC + 32'($urandom_range(0, 255) << 2) + ((sel == 3) ? 32'($urandom_range(0, 3)) : 32'd0);
      step(rv, rpc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
